// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT address sequencer files.
//   fsm_state_t   - sequencer control states
//   fft_cmd_width - address/command width for an N-point transform
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fsm_state_t;

  function automatic int fft_cmd_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: combinational radix-2 butterfly address mapping.
// For stage s and butterfly index j within the stage:
//   half = 2^s, k = j mod half, group = j / half
//   addr_a = group*2*half + k, addr_b = addr_a + half,
//   tf_addr = k << (CMD_WIDTH-1-s)
// Ports:
//   s       in  stage index (0 .. CMD_WIDTH-1)
//   j       in  butterfly index within the stage (0 .. N/2-1)
//   addr_a  out upper operand address
//   addr_b  out lower operand address
//   tf_addr out twiddle ROM address
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter  int N         = 16,
  localparam int CMD_WIDTH = fft_cmd_width(N)
) (
  input  logic [CMD_WIDTH-1:0] s,
  input  logic [CMD_WIDTH-2:0] j,
  output logic [CMD_WIDTH-1:0] addr_a,
  output logic [CMD_WIDTH-1:0] addr_b,
  output logic [CMD_WIDTH-1:0] tf_addr
);

  localparam logic [CMD_WIDTH-1:0] ONE     = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] TOP_BIT = CMD_WIDTH'(CMD_WIDTH - 1);

  logic [CMD_WIDTH-1:0] j_ext;
  logic [CMD_WIDTH-1:0] half;
  logic [CMD_WIDTH-1:0] low_mask;
  logic [CMD_WIDTH-1:0] k;
  logic [CMD_WIDTH-1:0] base;

  // group*2*half equals j with its low s bits cleared, shifted left once;
  // since j < N/2 the shifted value still fits in CMD_WIDTH bits, and bit s
  // of base is always clear, so adding half never carries out.
  always_comb begin
    j_ext    = {1'b0, j};
    half     = ONE << s;
    low_mask = half - ONE;
    k        = j_ext & low_mask;
    base     = (j_ext & ~low_mask) << 1;
    addr_a   = base | k;
    addr_b   = addr_a + half;
    tf_addr  = k << (TOP_BIT - s);
  end

endmodule

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer: in-place radix-2 FFT butterfly address sequencer.
// Runs CMD_WIDTH stages of N/2 butterflies each, pausing BF_LATENCY cycles
// between stages so the butterfly pipeline can drain.
// Optional feature: define FFT_SEQ_ABORT_EN to add the abort input.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   start     in  one-cycle request to run a transform (IDLE only)
//   hold      in  freezes issue while high (ISSUE only)
//   abort     in  (FFT_SEQ_ABORT_EN) cancel the transform, back to IDLE
//   busy      out transform in progress
//   done      out one-cycle completion pulse
//   bf_valid  out a butterfly is issued this cycle
//   rd_addr_a out upper operand address
//   rd_addr_b out lower operand address
//   tf_addr   out twiddle ROM address
//   m_in      out write-back tag {rd_addr_a, rd_addr_b}
//   stage     out current stage index
// All outputs are registered and follow the control state by one cycle.
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter  int N          = 16,
  parameter  int BF_LATENCY = 3,
  localparam int CMD_WIDTH  = fft_cmd_width(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   hold,
`ifdef FFT_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   bf_valid,
  output logic [CMD_WIDTH-1:0]   rd_addr_a,
  output logic [CMD_WIDTH-1:0]   rd_addr_b,
  output logic [CMD_WIDTH-1:0]   tf_addr,
  output logic [2*CMD_WIDTH-1:0] m_in,
  output logic [CMD_WIDTH-1:0]   stage
);

  localparam logic [CMD_WIDTH-2:0] J_LAST     = '1;
  localparam logic [CMD_WIDTH-1:0] STAGE_LAST = CMD_WIDTH'(CMD_WIDTH - 1);
  localparam logic [3:0]           DRAIN_LAST = 4'(BF_LATENCY - 1);

  fsm_state_t           state;
  fsm_state_t           state_nxt;
  logic [CMD_WIDTH-2:0] j_cnt;
  logic [CMD_WIDTH-2:0] j_nxt;
  logic [CMD_WIDTH-1:0] stage_cnt;
  logic [CMD_WIDTH-1:0] stage_nxt;
  logic [3:0]           drain_cnt;
  logic [3:0]           drain_nxt;
  logic                 issue_now;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic [CMD_WIDTH-1:0] gen_a;
  logic [CMD_WIDTH-1:0] gen_b;
  logic [CMD_WIDTH-1:0] gen_tf;

  fft_bf_addr_gen #(
    .N(N)
  ) u_addr_gen (
    .s      (stage_cnt),
    .j      (j_cnt),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tf_addr(gen_tf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      j_cnt     <= '0;
      stage_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      j_cnt     <= j_nxt;
      stage_cnt <= stage_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // j stops at J_LAST and is only reloaded when a new stage begins, so the
  // counter can never wrap past N/2-1.
  always_comb begin
    state_nxt = state;
    j_nxt     = j_cnt;
    stage_nxt = stage_cnt;
    drain_nxt = drain_cnt;
    issue_now = 1'b0;
    busy_nxt  = (state == ISSUE) || (state == DRAIN);
    done_nxt  = (state == FIN);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          j_nxt     = '0;
          stage_nxt = '0;
          drain_nxt = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue_now = 1'b1;
          if (j_cnt == J_LAST) begin
            state_nxt = DRAIN;
            drain_nxt = '0;
          end else begin
            j_nxt = j_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          if (stage_cnt == STAGE_LAST) begin
            state_nxt = FIN;
          end else begin
            state_nxt = ISSUE;
            stage_nxt = stage_cnt + 1'b1;
            j_nxt     = '0;
          end
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef FFT_SEQ_ABORT_EN
    // Abort overrides everything else decided above, including hold.
    if (abort && ((state == ISSUE) || (state == DRAIN))) begin
      state_nxt = IDLE;
      j_nxt     = '0;
      stage_nxt = '0;
      drain_nxt = '0;
      issue_now = 1'b0;
      busy_nxt  = 1'b0;
    end
`endif
  end

  // Address registers only load on an issue, so they stay frozen across
  // hold and drain cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      bf_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tf_addr   <= '0;
      m_in      <= '0;
      stage     <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      bf_valid <= issue_now;
      stage    <= stage_cnt;
      if (issue_now) begin
        rd_addr_a <= gen_a;
        rd_addr_b <= gen_b;
        tf_addr   <= gen_tf;
        m_in      <= {gen_a, gen_b};
      end
    end
  end

endmodule

// File: doc/fft_addr_sequencer.md
FFT_ADDR_SEQUENCER -- requirements
Module: fft_addr_sequencer

Interface
REQ-001 SHALL have parameter N, default 16: FFT length, power of two, 4 to 1024.
REQ-002 SHALL have parameter BF_LATENCY, default 3: butterfly pipeline depth in cycles, 1 to 15.
REQ-003 SHALL derive localparam CMD_WIDTH = $clog2(N).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run one transform.
REQ-007 SHALL have port hold, input, 1 bit: freezes issue while high.
REQ-008 SHALL have port busy, output, 1 bit: transform in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port bf_valid, output, 1 bit: a butterfly operation is issued this cycle.
REQ-011 SHALL have port rd_addr_a, output, CMD_WIDTH bits: upper butterfly operand address.
REQ-012 SHALL have port rd_addr_b, output, CMD_WIDTH bits: lower butterfly operand address.
REQ-013 SHALL have port tf_addr, output, CMD_WIDTH bits: twiddle ROM address.
REQ-014 SHALL have port m_in, output, 2*CMD_WIDTH bits: write-back tag {rd_addr_a, rd_addr_b}.
REQ-015 SHALL have port stage, output, CMD_WIDTH bits: current stage index.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, FIN.
REQ-017 SHALL move from IDLE to ISSUE on start; start in any other state is ignored.
REQ-018 SHALL, in ISSUE, step counter j from 0 to N/2-1, issuing one butterfly per non-hold cycle; with hold high, j and outputs freeze and bf_valid=0.
REQ-019 SHALL compute addresses for stage s with half=2^s, grp=j>>s, k=j&(half-1): rd_addr_a=grp*2*half+k; rd_addr_b=rd_addr_a+half; tf_addr=k<<(CMD_WIDTH-1-s).
REQ-020 SHALL register all outputs; the address, tag and bf_valid of one issue appear together in the same cycle.
REQ-021 SHALL go from ISSUE to DRAIN after issuing j=N/2-1, and hold DRAIN for exactly BF_LATENCY cycles with bf_valid=0; hold has no effect in DRAIN.
REQ-022 SHALL, at the end of DRAIN, go to ISSUE with stage+1 and j=0 if stage<CMD_WIDTH-1, otherwise go to FIN.
REQ-023 SHALL spend one cycle in FIN with done=1 and busy=0, then return to IDLE.
REQ-024 SHALL hold busy=1 in ISSUE and DRAIN only.
REQ-025 SHALL use counter arithmetic that never wraps beyond N/2-1; widths are exact, with no truncation of addresses.

Reset
REQ-026 SHALL, on rst_n low, go to IDLE and clear j, stage, busy, done, bf_valid, rd_addr_a, rd_addr_b, tf_addr and m_in to 0 immediately, including mid-transform.
REQ-027 SHALL resume only on a fresh start after rst_n deasserts; no pending work is retained.

Configuration
REQ-028 SHALL, with macro FFT_SEQ_ABORT_EN defined, add input abort (1 bit): abort high in ISSUE or DRAIN returns the FSM to IDLE on the next edge with busy=0, bf_valid=0 and no done pulse; abort has priority over hold and start.
REQ-029 SHALL, without FFT_SEQ_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-030 SHALL place the FSM state enum and the CMD_WIDTH derivation function in shared package fft_pkg.
REQ-031 SHALL use sub-module fft_bf_addr_gen for the combinational mapping of (s, j) to (addr_a, addr_b, tf_addr); all else is flat.

Verification (N=16, BF_LATENCY=3)
REQ-032 SHALL test start pulse with hold=0: 32 bf_valid cycles occur, and done rises 45 cycles after the start-sampling edge, lasting 1 cycle.
REQ-033 SHALL test issue order: stage0 j=0 gives (0,1,tf0); stage1 j=1 gives (1,3,tf4) and j=2 gives (4,6,tf0); stage3 j=1 gives (1,9,tf1); m_in matches {a,b} each time.
REQ-034 SHALL test hold high for 5 cycles at stage1 j=3: outputs freeze, bf_valid=0, done is delayed by exactly 5 cycles.
REQ-035 SHALL test rst_n pulled low mid-stage2: all outputs read 0 asynchronously, and a new start restarts at stage0 j=0.
REQ-036 SHALL test start asserted while busy: it is ignored, and the transform timing is unchanged.
REQ-037 SHALL test, with FFT_SEQ_ABORT_EN, abort during DRAIN of stage1: state is IDLE the next cycle, with no done pulse.
